pmem_responder: RTL

//  Physical-memory end of the pmem interface driven by cache_arbiter.

---
 rtl/pmem_responder.sv | 77 +++++++
 1 files changed

// File: rtl/pmem_responder.sv
// pmem_responder: single-outstanding line memory with fixed read/write latency and a one-cycle completion pulse.
module pmem_responder #(
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = 128,
  parameter int DEPTH_LINES = 4096,
  parameter int READ_LAT    = 4,
  parameter int WRITE_LAT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic              pmem_resp,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              busy,
  output logic              proto_err
);
  localparam int IW   = $clog2(DEPTH_LINES);
  localparam int MAXL = READ_LAT > WRITE_LAT ? READ_LAT : WRITE_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic op_wr;
  logic [IW-1:0] idx;
  logic [LINE_W-1:0] wdata;
  logic [LINE_W-1:0] mem [DEPTH_LINES];
  logic req, commit, unused_addr;
  logic [IW-1:0] req_idx;
  assign req = pmem_read | pmem_write;
  assign req_idx = pmem_address[4 +: IW];
  assign unused_addr = ^pmem_address;
  assign commit = state == BUSY && cnt == '0 && op_wr;
  // Backing store has no reset so its contents survive rst_n.
  always_ff @(posedge clk)
    if (commit) mem[idx] <= wdata;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      op_wr      <= 1'b0;
      idx        <= '0;
      wdata      <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
    end else
      case (state)
        IDLE: if (req) begin
          state     <= BUSY;
          busy      <= 1'b1;
          op_wr     <= pmem_write;
          idx       <= req_idx;
          wdata     <= pmem_wdata;
          cnt       <= pmem_write ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
          pmem_resp <= pmem_write ? (WRITE_LAT == 1) : (READ_LAT == 1);
          if (!pmem_write && READ_LAT == 1) pmem_rdata <= mem[req_idx];
          if (pmem_read && pmem_write) proto_err <= 1'b1;
        end
        BUSY: begin
          // Load resp and rdata one edge early so both are valid in the cnt==0 cycle.
          pmem_resp <= cnt == CW'(1);
          if (cnt == CW'(1) && !op_wr) pmem_rdata <= mem[idx];
          if ({pmem_read, pmem_write} != {!op_wr, op_wr}) proto_err <= 1'b1;
          if (cnt == '0) state <= DONE;
          else cnt <= cnt - 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule
